// File: rtl/ac_chk_pkg.sv
// Shared types and widths for the AC-control vector checker.
package ac_chk_pkg;

    localparam int CODE_W    = 4;
    localparam int ERR_W     = 5;
    localparam int NUM_CODES = 16;
    localparam int HOLD_W    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] cnt, input logic mis);
        return cnt + {{(ERR_W-1){1'b0}}, mis};
    endfunction

endpackage

// File: rtl/ac_hold_timer.sv
// Loadable up-counter; o_tc flags the last hold cycle (count == HOLD_CYCLES-1).
module ac_hold_timer
    import ac_chk_pkg::*;
#(
    parameter int HOLD_CYCLES = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [HOLD_W-1:0] TC_VAL = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] r_cnt;

    // Hold counter: load clears, enable advances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= {HOLD_W{1'b0}};
        end else if (i_load) begin
            r_cnt <= {HOLD_W{1'b0}};
        end else if (i_en) begin
            r_cnt <= r_cnt + HOLD_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/ac_vector_checker.sv
// Self-test sweep of codes 0..15 onto M/P/H/T, comparing AC against EXPECTED.
// Optional FIRST_FAIL_CAPTURE_EN adds first_fail / first_fail_vld outputs.
module ac_vector_checker
    import ac_chk_pkg::*;
#(
    parameter int          HOLD_CYCLES = 20,
    parameter logic [15:0] EXPECTED    = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ac_in,
    output logic             m_out,
    output logic             p_out,
    output logic             h_out,
    output logic             t_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    output logic [CODE_W-1:0] first_fail,
    output logic              first_fail_vld
`endif
);

    state_e              r_state;
    logic [CODE_W-1:0]   r_code;
    logic [CODE_W-1:0]   r_drive;
    logic [ERR_W-1:0]    r_err;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;

    logic                w_start_acc;
    logic                w_load;
    logic                w_en;
    logic                w_tc;
    logic                w_mis;
    logic [ERR_W-1:0]    w_err_nxt;

    // Timer control and sample-time comparison.
    always_comb begin
        w_start_acc = 1'b0;
        w_load      = 1'b0;
        w_en        = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                w_start_acc = start;
                w_load      = start;
            end
            DRIVE:   w_en   = 1'b1;
            SAMPLE:  w_load = 1'b1;
            default: w_load = 1'b1;
        endcase
        w_mis     = ac_in ^ EXPECTED[r_code];
        w_err_nxt = err_inc(r_err, w_mis);
    end

    ac_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_en   (w_en),
        .o_tc   (w_tc)
    );

    // Sweep FSM with registered drive/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_code  <= {CODE_W{1'b0}};
            r_drive <= {CODE_W{1'b0}};
            r_err   <= {ERR_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= DRIVE;
                        r_code  <= {CODE_W{1'b0}};
                        r_drive <= {CODE_W{1'b0}};
                        r_err   <= {ERR_W{1'b0}};
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else begin
                        r_drive <= {CODE_W{1'b0}};
                        r_busy  <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (w_tc) begin
                        r_state <= SAMPLE;
                    end else begin
                        r_state <= DRIVE;
                    end
                end
                SAMPLE: begin
                    r_err <= w_err_nxt;
                    if (r_code == CODE_W'(NUM_CODES - 1)) begin
                        r_state <= DONE;
                        r_drive <= {CODE_W{1'b0}};
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_nxt == {ERR_W{1'b0}});
                    end else begin
                        r_state <= DRIVE;
                        r_code  <= r_code + CODE_W'(1);
                        r_drive <= r_code + CODE_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_drive <= {CODE_W{1'b0}};
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign {m_out, p_out, h_out, t_out} = r_drive;
    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
    assign err_cnt = r_err;

`ifdef FIRST_FAIL_CAPTURE_EN
    logic [CODE_W-1:0] r_ff_code;
    logic              r_ff_vld;

    // Latch the code of the first mismatch in a sweep; later ones are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ff_code <= {CODE_W{1'b0}};
            r_ff_vld  <= 1'b0;
        end else if (w_start_acc) begin
            r_ff_code <= {CODE_W{1'b0}};
            r_ff_vld  <= 1'b0;
        end else if ((r_state == SAMPLE) && w_mis && !r_ff_vld) begin
            r_ff_code <= r_code;
            r_ff_vld  <= 1'b1;
        end else begin
            r_ff_code <= r_ff_code;
            r_ff_vld  <= r_ff_vld;
        end
    end

    assign first_fail     = r_ff_code;
    assign first_fail_vld = r_ff_vld;
`endif

endmodule

// File: tb/tb_ac_vector_checker.sv
// Randomized self-checking bench for ac_vector_checker (HOLD_CYCLES=4, EXPECTED=16'hA5A5).
module tb_ac_vector_checker;

    localparam int          HOLD = 4;
    localparam int          PER  = HOLD + 1;
    localparam int          SWEEP = 16 * PER;
    localparam logic [15:0] EXP  = 16'hA5A5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       ac_in;
    logic       m_out, p_out, h_out, t_out;
    logic       busy, done, pass;
    logic [4:0] err_cnt;
`ifdef FIRST_FAIL_CAPTURE_EN
    logic [3:0] first_fail;
    logic       first_fail_vld;
`endif

    logic [15:0] resp;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Model of the logic under test: AC response looked up from the current code.
    assign ac_in = resp[{m_out, p_out, h_out, t_out}];

    ac_vector_checker #(
        .HOLD_CYCLES(HOLD),
        .EXPECTED   (EXP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .ac_in   (ac_in),
        .m_out   (m_out),
        .p_out   (p_out),
        .h_out   (h_out),
        .t_out   (t_out),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt)
`ifdef FIRST_FAIL_CAPTURE_EN
        ,
        .first_fail     (first_fail),
        .first_fail_vld (first_fail_vld)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Number of codes c < upto whose response disagrees with the expected table.
    function automatic int n_mis(input logic [15:0] tbl, input int upto);
        int n = 0;
        for (int c = 0; c < upto; c++) begin
            if (tbl[c] !== EXP[c]) n++;
        end
        return n;
    endfunction

    function automatic int first_mis(input logic [15:0] tbl);
        for (int c = 0; c < 16; c++) begin
            if (tbl[c] !== EXP[c]) return c;
        end
        return 0;
    endfunction

    // Full sweep: per-cycle code/busy/done/err checks, optional ignored start at code 6.
    task automatic run_sweep(input string tag, input logic [15:0] tbl, input bit poke);
        logic [3:0] ecode;
        int         nerr;
        resp = tbl;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < SWEEP; k++) begin
            ecode = 4'(k / PER);
            check({tag, "_drive"}, {26'd0, done, busy, m_out, p_out, h_out, t_out},
                  {26'd0, 1'b0, 1'b1, ecode});
            check({tag, "_err"}, {27'd0, err_cnt}, 32'(n_mis(tbl, k / PER)));
            start = (poke && k == 6 * PER + 2) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        nerr = n_mis(tbl, 16);
        check({tag, "_end"}, {29'd0, done, busy, pass}, {29'd0, 1'b1, 1'b0, (nerr == 0)});
        check({tag, "_code0"}, {28'd0, m_out, p_out, h_out, t_out}, 32'd0);
        check({tag, "_errcnt"}, {27'd0, err_cnt}, 32'(nerr));
`ifdef FIRST_FAIL_CAPTURE_EN
        check({tag, "_ffvld"}, {31'd0, first_fail_vld}, {31'd0, (nerr != 0)});
        if (nerr != 0) check({tag, "_ff"}, {28'd0, first_fail}, 32'(first_mis(tbl)));
`endif
        @(negedge clk);
        check({tag, "_hold"}, {26'd0, done, pass, err_cnt == 5'(nerr), busy, 2'd0},
              {26'd0, 1'b1, (nerr == 0), 1'b1, 1'b0, 2'd0});
    endtask

    // Reset dropped while code 7 is on the lines.
    task automatic reset_mid;
        resp = 16'h0000;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 7 * PER + 2; k++) @(negedge clk);
        check("rst_pre_code", {28'd0, m_out, p_out, h_out, t_out}, 32'd7);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_outs", {24'd0, m_out, p_out, h_out, t_out, busy, done, pass, 1'b0},
              32'd0);
        check("rst_mid_err", {27'd0, err_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_idle", {28'd0, busy, done, m_out | p_out | h_out | t_out, pass}, 32'd0);
    endtask

    initial begin
        logic [15:0] rtbl;
        rst_n = 1'b0;
        start = 1'b0;
        resp  = EXP;
        repeat (3) @(negedge clk);
        check("reset_outs", {23'd0, m_out, p_out, h_out, t_out, busy, done, pass, err_cnt == 5'd0},
              32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        run_sweep("good", EXP, 1'b0);
        run_sweep("stuck0", 16'h0000, 1'b0);
        run_sweep("stuck1", 16'hFFFF, 1'b0);
        run_sweep("restart", EXP, 1'b0);
        run_sweep("ignore", EXP ^ 16'h0102, 1'b1);
        reset_mid();
        run_sweep("after_rst", EXP, 1'b0);
        run_sweep("inv5_11", EXP ^ 16'h0820, 1'b0);
        for (int r = 0; r < 4; r++) begin
            rtbl = 16'($urandom);
            run_sweep("rand", EXP ^ rtbl, ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
